matmul_stream_engine: RTL
=========================

Name: matmul_stream_engine

Overview:
Parametrised M x N x k matrix-multiply engine with AXI-Stream operand inputs (A, B) and a result stream (C), sequenced by a start/done control interface.
- Generalises the fixed 2x2 engine: any M, N, and a runtime k in 1..K_MAX.
- Adds full-throughput output, config validation, TLAST protocol checking, sticky done with software clear, and a maskable interrupt.
- Sits between the DMA stream fabric and the AXI-Lite control block.

Parameters:
DATA_W, 32, operand and result beat width
ACC_W, 32, accumulator width (ACC_W >= DATA_W); C beats carry acc[DATA_W-1:0] (sign-extended when ACC_W < DATA_W is illegal)
M, 2, rows of A and C
N, 2, columns of B and C
K_MAX, 8, maximum inner dimension; sizes buffers

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_a_tdata/tvalid/tlast  in  DATA_W/1/1  A operand stream, row-major A[i][kk]
s_axis_a_tready  out  1  A ready
s_axis_b_tdata/tvalid/tlast  in  DATA_W/1/1  B operand stream, row-major B[kk][j]
s_axis_b_tready  out  1  B ready
m_axis_c_tdata/tvalid/tlast  out  DATA_W/1/1  C result stream, row-major C[i][j]
m_axis_c_tready  in  1  C ready
cfg_k  in  16  inner dimension; sampled on start acceptance
start  in  1  level request; accepted only in IDLE
clear_done  in  1  clears done and err (W1C pulse from AXI-Lite)
irq_en  in  1  interrupt enable
busy  out  1  state != IDLE and state != DONE
done  out  1  sticky completion flag
err  out  1  sticky error flag
err_code  out  2  0 none, 1 bad cfg_k, 2 A tlast mismatch, 3 B tlast mismatch (first error wins)
irq  out  1  one-cycle pulse

Behaviour:
- Reset values: all readies, tvalid, tlast, tdata, busy, done, err, err_code, irq = 0; state = IDLE; counters = 0. Reset mid-operation aborts immediately; partial buffers are discarded.
- FSM states: IDLE, LOAD_A, LOAD_B, CLEAR, COMPUTE, OUTPUT, DONE.
- IDLE:
  - start=1 latches k_r = cfg_k and clears done, err, err_code.
  - If k_r == 0 or k_r > K_MAX: go to DONE with err=1, err_code=1, done=1, irq per irq_en. No stream beats are consumed.
  - Otherwise go to LOAD_A.
- LOAD_A:
  - tready=1 for exactly M*k_r beats; termination is count-based.
  - tlast is required on the last beat and only there. A mismatch sets err with code 2, but loading continues.
  - Go to LOAD_B after the final handshake.
- LOAD_B: same as LOAD_A with k_r*N beats and code 3. Then go to CLEAR.
- CLEAR: one cycle; zeroes the accumulators.
- COMPUTE:
  - Exactly k_r cycles; cycle kk adds A[i][kk]*B[kk][j] into acc[i][j] for all i, j in parallel.
  - Signed multiply; product and sum wrap modulo 2^ACC_W.
  - Then go to OUTPUT.
- OUTPUT:
  - tvalid rises the cycle after entry, independent of tready.
  - The next beat is loaded in the same cycle as a handshake, giving one beat per cycle under tready=1.
  - tdata/tlast are held stable while tvalid && !tready.
  - tlast is set only on beat M*N-1.
  - After the final handshake: tvalid=0, go to DONE, done=1, irq=irq_en for one cycle.
- DONE: returns to IDLE when start=0. start held high must not retrigger.
- clear_done clears done/err/err_code in any state. If clear_done coincides with a done set, the set wins.
- Operand buffers are stable outside LOAD states; accumulators are stable in OUTPUT and DONE.
- Readies are never asserted outside their own LOAD state.

Decomposition:
- Package matmul_pkg holds: state_t enum, err_code constants (ERR_NONE, ERR_CFG, ERR_A_LAST, ERR_B_LAST), and a clog2-based counter-width function.
- One sub-module, matmul_array_mac: parametrised M x N MAC array with en, clear, k index, A/B buffer inputs and C outputs.
- FSM, counters and output register stay in the top module.

Test Plan:
- M=N=2, k=2, A=[1,2,3,4], B=[5,6,7,8], tready=1 -> C beats 19,22,43,50 on consecutive cycles; tlast on beat 3; done=1; irq pulse with irq_en=1.
- Same data, tready toggling 1-0-0-1 -> identical values; tdata/tlast stable during stalls; exactly 4 handshakes.
- k=K_MAX=8, A all -1, B all 2 -> every C beat = -16 (0xFFFFFFF0).
- cfg_k=0, then cfg_k=9 -> no readies asserted; done=1, err=1, err_code=1 in each case.
- A tlast on beat 1 of 4 -> all 4 beats are still consumed; result computed; err_code=2; done=1.
- Reset asserted during OUTPUT beat 2 -> tvalid=0 and state IDLE immediately; a following run produces correct results; start held high through DONE does not relaunch.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLEAR,
        COMPUTE,
        OUTPUT,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_CFG    = 2'd1;
    localparam logic [1:0] ERR_A_LAST = 2'd2;
    localparam logic [1:0] ERR_B_LAST = 2'd3;

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_array_mac.sv
// M x N array of signed multiply-accumulate cells sharing one inner index k.
module matmul_array_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned M      = 2,
    parameter int unsigned N      = 2,
    parameter int unsigned K_MAX  = 8
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_en,
    input  logic                                 i_clear,
    input  logic [cnt_w(K_MAX)-1:0]              i_k,
    input  logic [M-1:0][K_MAX-1:0][DATA_W-1:0]  i_a_buf,
    input  logic [K_MAX-1:0][N-1:0][DATA_W-1:0]  i_b_buf,
    output logic [M-1:0][N-1:0][ACC_W-1:0]       o_c
);

    logic [M-1:0][N-1:0][ACC_W-1:0] r_acc;
    logic [M-1:0][N-1:0][ACC_W-1:0] w_prod;

    // Operands are sign-extended first so the low ACC_W product bits wrap correctly.
    function automatic logic [ACC_W-1:0] smul(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic signed [ACC_W-1:0] ea;
        logic signed [ACC_W-1:0] eb;
        ea = ACC_W'($signed(a));
        eb = ACC_W'($signed(b));
        return ea * eb;
    endfunction

    always_comb begin
        w_prod = '0;
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                w_prod[i][j] = smul(i_a_buf[i][i_k], i_b_buf[i_k][j]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            for (int unsigned i = 0; i < M; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    r_acc[i][j] <= r_acc[i][j] + w_prod[i][j];
                end
            end
        end
    end

    assign o_c = r_acc;

endmodule

// File: rtl/matmul_stream_engine.sv
// M x N x k matrix multiply fed by A/B AXI-Stream operands, emitting C row-major.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned M      = 2,
    parameter int unsigned N      = 2,
    parameter int unsigned K_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    input  logic              s_axis_a_tlast,
    output logic              s_axis_a_tready,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    input  logic              s_axis_b_tlast,
    output logic              s_axis_b_tready,
    output logic [DATA_W-1:0] m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    output logic              m_axis_c_tlast,
    input  logic              m_axis_c_tready,
    input  logic [15:0]       cfg_k,
    input  logic              start,
    input  logic              clear_done,
    input  logic              irq_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              irq
);

    localparam int unsigned MW      = cnt_w(M);
    localparam int unsigned NW      = cnt_w(N);
    localparam int unsigned KW      = cnt_w(K_MAX);
    localparam int unsigned MN_MAX  = (M > N) ? M : N;
    localparam int unsigned DIM_MAX = (MN_MAX > K_MAX) ? MN_MAX : K_MAX;
    localparam int unsigned IW      = cnt_w(DIM_MAX);

    state_t r_state, w_next;
    logic [15:0]                         r_k;
    logic [IW-1:0]                       r_row, r_col;
    logic [M-1:0][K_MAX-1:0][DATA_W-1:0] r_a_buf;
    logic [K_MAX-1:0][N-1:0][DATA_W-1:0] r_b_buf;
    logic [M-1:0][N-1:0][ACC_W-1:0]      w_c;
    logic                                r_c_valid, r_c_last;
    logic [DATA_W-1:0]                   r_c_data;
    logic                                r_done, r_err, r_irq;
    logic [1:0]                          r_err_code;

    logic       w_cfg_bad, w_start_acc, w_a_hs, w_b_hs, w_k_last, w_a_last, w_b_last;
    logic       w_c_hs, w_c_load, w_c_fin, w_done_set, w_err_set;
    logic [1:0] w_err_val;

    assign w_cfg_bad   = (cfg_k == '0) || (cfg_k > 16'(K_MAX));
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_a_hs      = (r_state == LOAD_A) && s_axis_a_tvalid;
    assign w_b_hs      = (r_state == LOAD_B) && s_axis_b_tvalid;
    assign w_k_last    = (16'(r_col) == r_k - 16'd1);
    assign w_a_last    = (r_row == IW'(M - 1)) && w_k_last;
    assign w_b_last    = (16'(r_row) == r_k - 16'd1) && (r_col == IW'(N - 1));
    assign w_c_hs      = r_c_valid && m_axis_c_tready;
    // First OUTPUT cycle primes beat 0; afterwards each handshake reloads the next beat.
    assign w_c_load    = (r_state == OUTPUT) && (!r_c_valid || (w_c_hs && !r_c_last));
    assign w_c_fin     = w_c_hs && r_c_last;
    assign w_done_set  = (w_start_acc && w_cfg_bad) || w_c_fin;

    always_comb begin
        w_err_set = 1'b0;
        w_err_val = ERR_NONE;
        if (w_a_hs && (s_axis_a_tlast != w_a_last)) begin
            w_err_set = 1'b1;
            w_err_val = ERR_A_LAST;
        end else if (w_b_hs && (s_axis_b_tlast != w_b_last)) begin
            w_err_set = 1'b1;
            w_err_val = ERR_B_LAST;
        end
    end

    always_comb begin
        w_next          = r_state;
        s_axis_a_tready = 1'b0;
        s_axis_b_tready = 1'b0;
        case (r_state)
            IDLE:    if (start) w_next = w_cfg_bad ? DONE : LOAD_A;
            LOAD_A: begin
                s_axis_a_tready = 1'b1;
                if (w_a_hs && w_a_last) w_next = LOAD_B;
            end
            LOAD_B: begin
                s_axis_b_tready = 1'b1;
                if (w_b_hs && w_b_last) w_next = CLEAR;
            end
            CLEAR:   w_next = COMPUTE;
            COMPUTE: if (w_k_last) w_next = OUTPUT;
            OUTPUT:  if (w_c_fin) w_next = DONE;
            DONE:    if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_c_valid <= 1'b0;
            r_c_last  <= 1'b0;
            r_c_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_k   <= cfg_k;
                    r_row <= '0;
                    r_col <= '0;
                end
                LOAD_A: if (w_a_hs) begin
                    if (w_k_last) begin
                        r_col <= '0;
                        r_row <= w_a_last ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                LOAD_B: if (w_b_hs) begin
                    if (r_col == IW'(N - 1)) begin
                        r_col <= '0;
                        r_row <= w_b_last ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                COMPUTE: r_col <= w_k_last ? '0 : r_col + 1'b1;
                OUTPUT: begin
                    if (w_c_load) begin
                        r_c_valid <= 1'b1;
                        r_c_data  <= w_c[MW'(r_row)][NW'(r_col)][DATA_W-1:0];
                        r_c_last  <= (r_row == IW'(M - 1)) && (r_col == IW'(N - 1));
                        if (r_col == IW'(N - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else if (w_c_fin) begin
                        r_c_valid <= 1'b0;
                        r_c_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_a_hs) r_a_buf[MW'(r_row)][KW'(r_col)] <= s_axis_a_tdata;
        if (w_b_hs) r_b_buf[KW'(r_row)][NW'(r_col)] <= s_axis_b_tdata;
    end

    // A concurrent set beats clear_done; a recorded error code is kept until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= w_done_set && irq_en;
            if (w_start_acc) begin
                r_done     <= w_cfg_bad;
                r_err      <= w_cfg_bad;
                r_err_code <= w_cfg_bad ? ERR_CFG : ERR_NONE;
            end else begin
                if (w_done_set)      r_done <= 1'b1;
                else if (clear_done) r_done <= 1'b0;
                if (w_err_set) begin
                    r_err <= 1'b1;
                    if (!r_err || clear_done) r_err_code <= w_err_val;
                end else if (clear_done) begin
                    r_err      <= 1'b0;
                    r_err_code <= ERR_NONE;
                end
            end
        end
    end

    matmul_array_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .M      (M),
        .N      (N),
        .K_MAX  (K_MAX)
    ) u_mac (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (r_state == COMPUTE),
        .i_clear (r_state == CLEAR),
        .i_k     (KW'(r_col)),
        .i_a_buf (r_a_buf),
        .i_b_buf (r_b_buf),
        .o_c     (w_c)
    );

    assign m_axis_c_tdata  = r_c_data;
    assign m_axis_c_tvalid = r_c_valid;
    assign m_axis_c_tlast  = r_c_last;
    assign busy            = (r_state != IDLE) && (r_state != DONE);
    assign done            = r_done;
    assign err             = r_err;
    assign err_code        = r_err_code;
    assign irq             = r_irq;

endmodule
